// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
//   state_e : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused)
//   clog2   : ceiling log2, used to size the bit counter
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor cell, purely combinational.
//   a, b   : minuend / subtrahend bits
//   bin    : borrow in
//   diff   : a - b - bin (bit)
//   borrow : borrow out
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, one bit per clock, LSB first.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin an operation (sampled only in IDLE)
//   a, b, bin    : operands, latched on the accepting edge
//   busy         : high while bits are being processed (RUN)
//   done         : one-cycle pulse when diff/bout become valid
//   diff, bout   : a - b - bin mod 2^WIDTH, final borrow
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;

  logic             bit_d;
  logic             bit_nb;

  full_sub u_bit (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .bin    (brw_q),
    .diff   (bit_d),
    .borrow (bit_nb)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = bit_nb;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bout_d  = bit_nb;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
